alu_chain_ctrl: RTL



---
 rtl/alu_chain_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_chain_ctrl.sv
// Multi-word ALU sequencer: streams two operand banks LSW-first through an external
// 32-bit ALU with carry ripple. Define ALU_CHAIN_OVF_EN to enable signed-overflow status.
module alu_chain_ctrl #(
    parameter int WORDS = 4,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [AW:0]   len,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic          busy,
    output logic          done,
    output logic          carry_out,
    output logic          zero_out,
    output logic          ovf_out,
    output logic [31:0]   alu_A,
    output logic [31:0]   alu_B,
    output logic          alu_Cin,
    output logic [4:0]    alu_Card,
    input  logic [31:0]   alu_F,
    input  logic          alu_Cout,
    input  logic          alu_Zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW:0]   MAX_LEN = (AW+1)'(WORDS);
    localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [2:0]    op_q, op_d;
    logic [AW:0]   len_q, len_d;
    logic          carry_q, carry_d;
    logic          zero_acc_q, zero_acc_d;
    logic          carry_out_q, carry_out_d;
    logic          zero_out_q, zero_out_d;

    logic [31:0]   bank_a_q [WORDS];
    logic [31:0]   bank_b_q [WORDS];
    logic [31:0]   result_q [WORDS];

    logic          last_word;
    logic          is_arith;
    logic          launch;
    logic          a_we, b_we, res_we;
    logic [AW:0]   len_eff;

    assign last_word = ({1'b0, idx_q} == (len_q - LEN_ONE));
    assign is_arith  = (op_q < 3'd3);
    assign launch    = (state_q == S_IDLE) && start;
    // Lengths beyond the bank depth are clamped rather than wrapping the index.
    assign len_eff   = (len > MAX_LEN) ? MAX_LEN : len;

    assign a_we   = (state_q == S_IDLE) && wr_en && !wr_sel;
    assign b_we   = (state_q == S_IDLE) && wr_en &&  wr_sel;
    assign res_we = (state_q == S_RUN);

    assign rd_data   = result_q[rd_addr];
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign carry_out = carry_out_q;
    assign zero_out  = zero_out_q;

    always_comb begin
        alu_A    = '0;
        alu_B    = '0;
        alu_Cin  = 1'b0;
        alu_Card = '0;
        if (state_q == S_RUN) begin
            alu_A   = bank_a_q[idx_q];
            alu_B   = bank_b_q[idx_q];
            alu_Cin = carry_q;
            // Arithmetic codes: even = first word (no carry in), odd = chained word.
            if (is_arith) begin
                alu_Card = {1'b0, op_q, 1'b0} + ((idx_q == '0) ? 5'd0 : 5'd1);
            end else begin
                alu_Card = {2'b00, op_q} + 5'd7;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_d        = op_q;
        len_d       = len_q;
        carry_d     = carry_q;
        zero_acc_d  = zero_acc_q;
        carry_out_d = carry_out_q;
        zero_out_d  = zero_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    carry_out_d = 1'b0;
                    if (len == '0) begin
                        zero_out_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        zero_out_d = 1'b0;
                        op_d       = op;
                        len_d      = len_eff;
                        idx_d      = '0;
                        carry_d    = 1'b0;
                        zero_acc_d = 1'b1;
                        state_d    = S_RUN;
                    end
                end
            end
            S_RUN: begin
                carry_d    = alu_Cout;
                zero_acc_d = zero_acc_q & alu_Zero;
                idx_d      = idx_q + IDX_ONE;
                if (last_word) begin
                    carry_out_d = alu_Cout;
                    zero_out_d  = zero_acc_q & alu_Zero;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            op_q        <= '0;
            len_q       <= '0;
            carry_q     <= 1'b0;
            zero_acc_q  <= 1'b0;
            carry_out_q <= 1'b0;
            zero_out_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            len_q       <= len_d;
            carry_q     <= carry_d;
            zero_acc_q  <= zero_acc_d;
            carry_out_q <= carry_out_d;
            zero_out_q  <= zero_out_d;
        end
    end

    // Operand and result storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (a_we) begin
            bank_a_q[wr_addr] <= wr_data;
        end
        if (b_we) begin
            bank_b_q[wr_addr] <= wr_data;
        end
        if (res_we) begin
            result_q[idx_q] <= alu_F;
        end
    end

`ifdef ALU_CHAIN_OVF_EN
    logic ovf_q, ovf_d;
    logic ovf_word;
    logic sign_a, sign_b, sign_f;

    assign sign_a = alu_A[31];
    assign sign_b = alu_B[31];
    assign sign_f = alu_F[31];

    always_comb begin
        ovf_word = 1'b0;
        case (op_q)
            3'd0:    ovf_word = (sign_a == sign_b) && (sign_f != sign_a);
            3'd1:    ovf_word = (sign_a != sign_b) && (sign_f != sign_a);
            3'd2:    ovf_word = (sign_a != sign_b) && (sign_f != sign_b);
            default: ovf_word = 1'b0;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (launch) begin
            ovf_d = 1'b0;
        end else if ((state_q == S_RUN) && last_word) begin
            ovf_d = ovf_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_out = ovf_q;
`else
    assign ovf_out = 1'b0;
`endif

endmodule
